// File: rtl/rect_plotter_if.sv
// rect_plotter_if
//   Draw-command channel of the rectangle plotter (valid/ready handshake).
//   cmd_valid  : a command is present on the cmd_* fields
//   cmd_ready  : the plotter can accept a command this cycle
//   cmd_x      : left column of the rectangle
//   cmd_y      : top row of the rectangle
//   cmd_w      : width in pixels (0..255)
//   cmd_h      : height in pixels (0..127)
//   cmd_colour : RGB colour, one bit per channel
//   master drives the command and observes ready; slave is the plotter.
interface rect_plotter_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x;
    logic [6:0] cmd_y;
    logic [7:0] cmd_w;
    logic [6:0] cmd_h;
    logic [2:0] cmd_colour;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
        output cmd_ready
    );
endinterface

// File: rtl/rect_plotter.sv
// rect_plotter
//   Fills a rectangle into a VGA-adapter framebuffer, one pixel per clock,
//   scanning row-major. Pixels falling outside H_RES x V_RES still consume a
//   cycle but are not written.
//   clk     : single clock, rising edge
//   resetn  : asynchronous active-low reset
//   cmd     : draw-command channel (slave side)
//   abort   : synchronous cancel of the command in progress
//   x, y    : pixel coordinate to the adapter
//   colour  : pixel colour to the adapter
//   plot    : write strobe, x/y/colour valid when high
//   busy    : high while a command is executing (DRAW or FINISH)
//   done    : one-cycle pulse on normal completion
module rect_plotter #(
    parameter int H_RES = 160,
    parameter int V_RES = 120
) (
    input  logic                 clk,
    input  logic                 resetn,
    rect_plotter_if.slave        cmd,
    input  logic                 abort,
    output logic [7:0]           x,
    output logic [6:0]           y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic                 busy,
    output logic                 done
);
    localparam logic [8:0] H_LIM = 9'(H_RES);
    localparam logic [7:0] V_LIM = 8'(V_RES);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FINISH} state_t;

    state_t     r_state;
    logic [7:0] r_lx, r_w, r_c;
    logic [6:0] r_ly, r_h, r_r;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_colour;
    logic       r_plot, r_busy, r_done;

    logic       w_col_last, w_row_last;
    logic [7:0] w_c_nxt;
    logic [6:0] w_r_nxt;
    logic [8:0] w_x_sum;
    logic [7:0] w_y_sum;
    logic       w_nxt_vis, w_hs_vis;

    // Counters hold the pixel currently on the outputs; the outputs for the
    // following pixel are computed from the advanced counters so that x/y/plot
    // stay registered while still visiting one pixel per clock.
    assign w_col_last = (r_c == r_w - 8'd1);
    assign w_row_last = (r_r == r_h - 7'd1);
    assign w_c_nxt    = w_col_last ? 8'd0 : r_c + 8'd1;
    assign w_r_nxt    = w_col_last ? r_r + 7'd1 : r_r;
    // Sums are one bit wider than the outputs so clipping sees the true
    // coordinate even when the truncated output wraps.
    assign w_x_sum    = {1'b0, r_lx} + {1'b0, w_c_nxt};
    assign w_y_sum    = {1'b0, r_ly} + {1'b0, w_r_nxt};
    assign w_nxt_vis  = (w_x_sum < H_LIM) && (w_y_sum < V_LIM);
    assign w_hs_vis   = ({1'b0, cmd.cmd_x} < H_LIM) && ({1'b0, cmd.cmd_y} < V_LIM);

    assign cmd.cmd_ready = (r_state == S_IDLE);
    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_lx     <= '0;
            r_ly     <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_c      <= '0;
            r_r      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_plot <= 1'b0;
                    if (cmd.cmd_valid) begin
                        r_lx     <= cmd.cmd_x;
                        r_ly     <= cmd.cmd_y;
                        r_w      <= cmd.cmd_w;
                        r_h      <= cmd.cmd_h;
                        r_c      <= '0;
                        r_r      <= '0;
                        r_colour <= cmd.cmd_colour;
                        r_busy   <= 1'b1;
                        if (cmd.cmd_w != 8'd0 && cmd.cmd_h != 7'd0) begin
                            r_state <= S_DRAW;
                            r_x     <= cmd.cmd_x;
                            r_y     <= cmd.cmd_y;
                            r_plot  <= w_hs_vis;
                        end else begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_DRAW: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_plot  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (w_col_last && w_row_last) begin
                        r_state <= S_FINISH;
                        r_plot  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_c    <= w_c_nxt;
                        r_r    <= w_r_nxt;
                        r_x    <= w_x_sum[7:0];
                        r_y    <= w_y_sum[6:0];
                        r_plot <= w_nxt_vis;
                    end
                end
                S_FINISH: begin
                    // Abort here lands in the same place as normal exit.
                    r_state <= S_IDLE;
                    r_plot  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_plot  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rect_plotter.sv
module tb_rect_plotter;
    logic       clk;
    logic       resetn;
    logic       abort;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;
    int         checks = 0;
    int         errors = 0;

    rect_plotter_if bus ();

    rect_plotter #(.H_RES(160), .V_RES(120)) dut (
        .clk(clk), .resetn(resetn), .cmd(bus.slave), .abort(abort),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called #1 after an edge with the plotter idle; returns #1 after the
    // handshake edge, i.e. inside the first cycle of the command.
    task automatic issue(input logic [7:0] ix, input logic [6:0] iy,
                         input logic [7:0] iw, input logic [6:0] ih,
                         input logic [2:0] ic);
        bus.cmd_x = ix; bus.cmd_y = iy; bus.cmd_w = iw; bus.cmd_h = ih;
        bus.cmd_colour = ic; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; abort = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_x = '0; bus.cmd_y = '0;
        bus.cmd_w = '0; bus.cmd_h = '0; bus.cmd_colour = '0;
        #2;
        checks++;
        if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || x !== 8'd0 ||
            y !== 7'd0 || colour !== 3'd0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state plot=%b done=%b busy=%b x=%0d y=%0d col=%b rdy=%b expected 0 0 0 0 0 000 rdy=1",
                     plot, done, busy, x, y, colour, bus.cmd_ready);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release rdy=%b busy=%b expected rdy=1 busy=0", bus.cmd_ready, busy);
        end
    endtask

    task automatic test_basic();
        logic [7:0] ex [6] = '{8'd10, 8'd11, 8'd12, 8'd10, 8'd11, 8'd12};
        logic [6:0] ey [6] = '{7'd20, 7'd20, 7'd20, 7'd21, 7'd21, 7'd21};
        issue(8'd10, 7'd20, 8'd3, 7'd2, 3'b010);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            checks++;
            if (plot !== 1'b1 || x !== ex[k] || y !== ey[k] || colour !== 3'b010 ||
                done !== 1'b0 || busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL basic_pix%0d x=%0d y=%0d plot=%b col=%b done=%b busy=%b expected x=%0d y=%0d plot=1 col=010 done=0 busy=1",
                         k, x, y, plot, colour, done, busy, ex[k], ey[k]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || plot !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_finish done=%b plot=%b busy=%b expected 1 0 1", done, plot, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || bus.cmd_ready !== 1'b1 || colour !== 3'b010) begin
            errors++;
            $display("FAIL basic_idle done=%b busy=%b rdy=%b col=%b expected 0 0 1 010", done, busy, bus.cmd_ready, colour);
        end
    endtask

    task automatic test_clip();
        // Visible pixels are (158,118) (159,118) (158,119) (159,119): k=0,1,4,5.
        logic [11:0] ep = 12'b0000_0011_0011;
        int nplot = 0;
        issue(8'd158, 7'd118, 8'd4, 7'd3, 3'b101);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (plot === 1'b1) nplot++;
            checks++;
            if (plot !== ep[k] || x !== 8'(158 + k % 4) || y !== 7'(118 + k / 4) ||
                done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL clip_pix%0d x=%0d y=%0d plot=%b done=%b expected x=%0d y=%0d plot=%b done=0",
                         k, x, y, plot, done, 158 + k % 4, 118 + k / 4, ep[k]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || plot !== 1'b0 || nplot != 4) begin
            errors++;
            $display("FAIL clip_finish done=%b plot=%b plots=%0d expected done=1 plot=0 plots=4", done, plot, nplot);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        // x sums 254..257 truncate to 254,255,0,1 but are all off-screen.
        logic [7:0] ex [4] = '{8'd254, 8'd255, 8'd0, 8'd1};
        issue(8'd254, 7'd0, 8'd4, 7'd1, 3'b001);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            checks++;
            if (plot !== 1'b0 || x !== ex[k] || y !== 7'd0) begin
                errors++;
                $display("FAIL wrap_pix%0d x=%0d y=%0d plot=%b expected x=%0d y=0 plot=0", k, x, y, plot, ex[k]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_finish done=%b expected 1", done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        logic [7:0] vw [2] = '{8'd0, 8'd3};
        logic [6:0] vh [2] = '{7'd5, 7'd0};
        for (int v = 0; v < 2; v++) begin
            issue(8'd5, 7'd5, vw[v], vh[v], 3'b011);
            checks++;
            if (busy !== 1'b1 || done !== 1'b1 || plot !== 1'b0 || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL zero%0d_finish busy=%b done=%b plot=%b rdy=%b expected 1 1 0 0", v, busy, done, plot, bus.cmd_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || plot !== 1'b0 || bus.cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL zero%0d_idle busy=%b done=%b plot=%b rdy=%b expected 0 0 0 1", v, busy, done, plot, bus.cmd_ready);
            end
        end
    endtask

    task automatic test_abort();
        int nplot = 0;
        int bad = 0;
        issue(8'd30, 7'd40, 8'd5, 7'd5, 3'b111);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (plot === 1'b1) nplot++;
        end
        // Sampled on the edge that would start the 4th DRAW cycle.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.cmd_ready !== 1'b1 || nplot != 3) begin
            errors++;
            $display("FAIL abort_stop plot=%b busy=%b done=%b rdy=%b plots=%0d expected 0 0 0 1 plots=3",
                     plot, busy, done, bus.cmd_ready, nplot);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || plot !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_quiet bad_cycles=%0d expected 0", bad);
        end
        // Abort in IDLE is ignored and the simultaneous command is taken.
        abort = 1'b1;
        issue(8'd7, 7'd8, 8'd1, 7'd1, 3'b110);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1 || plot !== 1'b1 || x !== 8'd7 || y !== 7'd8 || colour !== 3'b110) begin
            errors++;
            $display("FAIL abort_idle busy=%b plot=%b x=%0d y=%0d col=%b expected 1 1 7 8 110", busy, plot, x, y, colour);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle_done done=%b expected 1", done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        issue(8'd50, 7'd60, 8'd4, 7'd4, 3'b011);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || x !== 8'd0 || y !== 7'd0 ||
            colour !== 3'd0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL resetmid_async plot=%b busy=%b x=%0d y=%0d col=%b rdy=%b expected 0 0 0 0 000 1",
                     plot, busy, x, y, colour, bus.cmd_ready);
        end
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL resetmid_after plot=%b done=%b busy=%b expected 0 0 0", plot, done, busy);
        end
        issue(8'd1, 7'd2, 8'd1, 7'd1, 3'b001);
        checks++;
        if (plot !== 1'b1 || x !== 8'd1 || y !== 7'd2 || colour !== 3'b001) begin
            errors++;
            $display("FAIL resetmid_newcmd plot=%b x=%0d y=%0d col=%b expected 1 1 2 001", plot, x, y, colour);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL resetmid_done done=%b expected 1", done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] ex [4] = '{8'd20, 8'd21, 8'd20, 8'd21};
        logic [6:0] ey [4] = '{7'd30, 7'd30, 7'd31, 7'd31};
        int n = 0;
        issue(8'd20, 7'd30, 8'd2, 7'd2, 3'b100);
        bus.cmd_x = 8'd99; bus.cmd_y = 7'd99; bus.cmd_w = 8'd7; bus.cmd_h = 7'd7;
        bus.cmd_colour = 3'b001; bus.cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            checks++;
            if (plot !== 1'b1 || x !== ex[k] || y !== ey[k] || colour !== 3'b100 || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_pix%0d x=%0d y=%0d plot=%b col=%b rdy=%b expected x=%0d y=%0d plot=1 col=100 rdy=0",
                         k, x, y, plot, colour, bus.cmd_ready, ex[k], ey[k]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_finish done=%b rdy=%b expected 1 0", done, bus.cmd_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap rdy=%b busy=%b done=%b expected 1 0 0", bus.cmd_ready, busy, done);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || plot !== 1'b1 || x !== 8'd99 || y !== 7'd99 || colour !== 3'b001) begin
            errors++;
            $display("FAIL b2b_second busy=%b plot=%b x=%0d y=%0d col=%b expected 1 1 99 99 001", busy, plot, x, y, colour);
        end
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 49) begin
            errors++;
            $display("FAIL b2b_length cycles_to_done=%0d expected 49", n);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_wrap();
        test_zero();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
